mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the byte-wide bus driven by mc (mem_wr/mem_addr/mem_w_data -> mem_r_data).
//   Provides byte-addressed RAM with 1-cycle registered read latency, plus a memory-mapped I/O window.
//   The I/O window holds a host-output FIFO, a host-input FIFO, a status byte and a halt flag.
//   Sits between mc and the top-level host/UART bridge.
// PARAMETERS
//   ADDR_WIDTH   17   RAM address bits; RAM size = 2**ADDR_WIDTH bytes
//   FIFO_DEPTH   16   entries in each I/O FIFO (power of two, >= 2)
// PORTS
//   clk_in         in   1    clock; all state changes on rising edge
//   rst_n_in       in   1    asynchronous, active-low reset
//   rdy_in         in   1    0 = freeze: no RAM write, no FIFO push/pop, mem_r_data holds
//   mem_wr         in   1    1 = write, 0 = read; an access is presented every cycle
//   mem_addr       in   32   byte address
//   mem_w_data     in   8    write byte
//   mem_r_data     out  8    read byte, valid the cycle after the address is sampled
//   io_out_data    out  8    head of the output FIFO
//   io_out_valid   out  1    output FIFO not empty
//   io_out_ready   in   1    host accepts io_out_data when valid & ready
//   io_in_data     in   8    byte from host
//   io_in_valid    in   1    host offers io_in_data
//   io_in_ready    out  1    input FIFO not full
//   io_overflow    out  1    sticky: a write to a full output FIFO dropped a byte
//   halt           out  1    sticky: program wrote the halt register
// BEHAVIOUR
//   Decode: io_sel = (mem_addr[17:16] == 2'b11).
//     Otherwise RAM at mem_addr[ADDR_WIDTH-1:0]; higher address bits are ignored, so addresses wrap.
//   RAM write: on mem_wr=1 & !io_sel & rdy_in, the byte is written at the clock edge.
//   RAM read: mem_r_data <= ram[addr] at the edge.
//     Read-during-write to the same address returns the new byte.
//   I/O map, low byte only (mem_addr[2:0]):
//     0x30000 W: push mem_w_data into the output FIFO; if full, drop it and set io_overflow.
//     0x30000 R: mem_r_data <= input FIFO head and pop; if empty, return 8'h00 with no pop.
//     0x30004 W: set halt (data ignored).
//     0x30004 R: mem_r_data <= {6'b0, in_empty, out_full}. No side effect.
//     Any other I/O offset: reads return 8'h00, writes are ignored.
//   Side effects fire on EVERY rdy_in cycle that presents the access.
//     The initiator parks mem_addr outside the I/O window when idle; the responder does no de-duplication.
//   FIFOs: circular buffers with a (log2 FIFO_DEPTH + 1)-bit count.
//     Pointers wrap modulo FIFO_DEPTH.
//     A push and a pop in the same cycle are both honoured and leave count unchanged.
//     Input FIFO: push when io_in_valid & io_in_ready; pop on the bus read described above.
//       When full, the simultaneous bus pop does NOT raise io_in_ready in the same cycle.
//     Output FIFO: pop when io_out_valid & io_out_ready; push on the bus write described above.
//       If full and popped in the same cycle, the bus push is accepted and io_overflow is not set.
//     Host-side handshakes ignore rdy_in.
//   Reset (async, rst_n_in=0), effective immediately and mid-transfer:
//     mem_r_data=0, both FIFOs empty, io_out_valid=0, io_in_ready=1, io_overflow=0, halt=0.
//     RAM contents are not reset.
//   io_overflow and halt clear only on reset.
// TESTING
//   Write 0xA5 @0x00010, then read 0x00010 -> mem_r_data=0xA5 one cycle after the read address is sampled.
//   Write 0x3C @0x20000 with ADDR_WIDTH=17 -> read @0x00000 returns 0x3C (wrap).
//   Push 17 bytes to 0x30000 with io_out_ready=0 -> io_out_valid=1, io_overflow=1, 16 bytes drain in order.
//   Host pushes 0x41; bus reads 0x30000 twice -> 0x41, then 0x00; status read 0x30004 -> 0x02.
//   Write 0x30004 -> halt=1; assert rst_n_in mid-stream -> all outputs return to reset values asynchronously.
//   rdy_in=0 during a write to 0x30000 -> no push; write completes once rdy_in=1.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - bus and host-side signal bundle for mem_responder
//
// Purpose: groups the mc byte bus (rdy_in, mem_wr, mem_addr, mem_w_data,
// mem_r_data) and the host I/O streams (io_out_*, io_in_*, io_overflow, halt).
// Modports:
//   master - the initiator/host side (drives the bus request and host inputs)
//   slave  - the responder side (mem_responder)
interface mem_responder_if;
  logic        rdy_in;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_w_data;
  logic [7:0]  mem_r_data;
  logic [7:0]  io_out_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [7:0]  io_in_data;
  logic        io_in_valid;
  logic        io_in_ready;
  logic        io_overflow;
  logic        halt;

  modport master (
    output rdy_in, mem_wr, mem_addr, mem_w_data,
    output io_out_ready, io_in_data, io_in_valid,
    input  mem_r_data, io_out_data, io_out_valid, io_in_ready, io_overflow, halt
  );

  modport slave (
    input  rdy_in, mem_wr, mem_addr, mem_w_data,
    input  io_out_ready, io_in_data, io_in_valid,
    output mem_r_data, io_out_data, io_out_valid, io_in_ready, io_overflow, halt
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte RAM with registered read plus memory-mapped host I/O FIFOs
//
// Purpose: memory-side responder for the mc byte bus. Byte RAM of
// 2**ADDR_WIDTH bytes with one-cycle registered read, and an I/O window at
// mem_addr[17:16] == 2'b11 holding an output FIFO, an input FIFO, a status
// byte and a sticky halt flag.
// Ports:
//   clk_in    - clock, rising edge
//   rst_n_in  - asynchronous active-low reset
//   bus       - mem_responder_if.slave: bus request/response and host streams

// Circular-buffer FIFO used for both host directions.
//   push/push_data - enqueue request (accepted when not full, or when a pop
//                    happens in the same cycle)
//   pop            - dequeue request (ignored when empty)
//   head           - oldest entry; meaningful only when !empty
//   empty/full     - derived from the registered count
module mem_responder_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16
) (
  input logic               clk_in,
  input logic               rst_n_in,
  mem_responder_if.slave    bus
);
  localparam int RAM_BYTES = 2 ** ADDR_WIDTH;

  logic [7:0]            ram [RAM_BYTES];
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  io_sel;
  logic [2:0]            io_off;
  logic                  fifo_sel;
  logic                  ctrl_sel;

  logic [7:0]            r_data;
  logic [7:0]            r_next;
  logic                  overflow;
  logic                  halted;

  logic                  out_push_req;
  logic                  out_pop;
  logic [7:0]            out_head;
  logic                  out_empty;
  logic                  out_full;

  logic                  in_push;
  logic                  in_pop_req;
  logic [7:0]            in_head;
  logic                  in_empty;
  logic                  in_full;

  logic                  unused_addr_bits;

  // Upper address bits only alias; they take no part in decode.
  assign unused_addr_bits = ^bus.mem_addr[31:18];

  assign io_sel   = (bus.mem_addr[17:16] == 2'b11);
  assign io_off   = bus.mem_addr[2:0];
  assign ram_addr = bus.mem_addr[ADDR_WIDTH-1:0];
  assign fifo_sel = io_sel && (io_off == 3'd0);
  assign ctrl_sel = io_sel && (io_off == 3'd4);

  // Bus-side FIFO traffic is qualified by rdy_in; host-side is not.
  assign out_push_req = bus.rdy_in & bus.mem_wr & fifo_sel;
  assign out_pop      = ~out_empty & bus.io_out_ready;
  assign in_pop_req   = bus.rdy_in & ~bus.mem_wr & fifo_sel;
  assign in_push      = bus.io_in_valid & ~in_full;

  mem_responder_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_out_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (out_push_req),
    .push_data (bus.mem_w_data),
    .pop       (out_pop),
    .head      (out_head),
    .empty     (out_empty),
    .full      (out_full)
  );

  mem_responder_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_in_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (in_push),
    .push_data (bus.io_in_data),
    .pop       (in_pop_req),
    .head      (in_head),
    .empty     (in_empty),
    .full      (in_full)
  );

  // Read-data selection. A RAM write returns the byte being written so a
  // same-address read-during-write sees the new value.
  always_comb begin
    r_next = 8'h00;
    if (!io_sel) begin
      r_next = bus.mem_wr ? bus.mem_w_data : ram[ram_addr];
    end else if (!bus.mem_wr) begin
      if (fifo_sel)      r_next = in_empty ? 8'h00 : in_head;
      else if (ctrl_sel) r_next = {6'b0, in_empty, out_full};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_data   <= 8'h00;
      overflow <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (bus.rdy_in) r_data <= r_next;
      // Drop only when full and nothing leaves this cycle.
      if (out_push_req && out_full && !out_pop) overflow <= 1'b1;
      if (bus.rdy_in && bus.mem_wr && ctrl_sel) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus.rdy_in && bus.mem_wr && !io_sel) ram[ram_addr] <= bus.mem_w_data;
  end

  assign bus.mem_r_data   = r_data;
  assign bus.io_out_data  = out_head;
  assign bus.io_out_valid = ~out_empty;
  assign bus.io_in_ready  = ~in_full;
  assign bus.io_overflow  = overflow;
  assign bus.halt         = halted;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;
  localparam int AW    = 17;
  localparam int DEPTH = 16;
  localparam int RAM_SIZE = 2 ** AW;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  mem_responder_if mif ();

  mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (mif.slave)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queues for the FIFOs, sparse array for RAM.
  logic [7:0] m_in[$];
  logic [7:0] m_out[$];
  logic [7:0] m_ram[int];
  logic [7:0] m_r;
  bit         m_r_known;
  bit         m_ovf;
  bit         m_halt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    if (m_r_known) chk("mem_r_data", mif.mem_r_data, m_r);
    chk("io_out_valid", mif.io_out_valid, m_out.size() > 0);
    if (m_out.size() > 0) chk("io_out_data", mif.io_out_data, m_out[0]);
    chk("io_in_ready", mif.io_in_ready, m_in.size() < DEPTH);
    chk("io_overflow", mif.io_overflow, m_ovf);
    chk("halt", mif.halt, m_halt);
  endtask

  // One clock: predict from current inputs and model state, clock, compare.
  task automatic step();
    int in_n = m_in.size();
    int out_n = m_out.size();
    bit out_pop = (out_n > 0) && mif.io_out_ready;
    bit in_push = mif.io_in_valid && (in_n < DEPTH);
    bit io = (mif.mem_addr[17:16] == 2'b11);
    int off = int'(mif.mem_addr % 8);
    int a = int'(mif.mem_addr % RAM_SIZE);
    bit out_push = 0;
    logic [7:0] nr = m_r;
    bit nk = m_r_known;
    if (mif.rdy_in) begin
      if (!io) begin
        if (mif.mem_wr) begin
          m_ram[a] = mif.mem_w_data;
          nr = mif.mem_w_data;
          nk = 1;
        end else if (m_ram.exists(a)) begin
          nr = m_ram[a];
          nk = 1;
        end else begin
          nk = 0;
        end
      end else if (mif.mem_wr) begin
        nk = 0;
        if (off == 0) begin
          if (out_n < DEPTH || out_pop) out_push = 1;
          else m_ovf = 1;
        end else if (off == 4) begin
          m_halt = 1;
        end
      end else begin
        nk = 1;
        if (off == 0) nr = (in_n > 0) ? m_in.pop_front() : 8'h00;
        else if (off == 4) nr = 8'(((in_n == 0) ? 2 : 0) + ((out_n == DEPTH) ? 1 : 0));
        else nr = 8'h00;
      end
    end
    if (out_pop) void'(m_out.pop_front());
    if (out_push) m_out.push_back(mif.mem_w_data);
    if (in_push) m_in.push_back(mif.io_in_data);
    @(posedge clk_in);
    #1;
    m_r = nr;
    m_r_known = nk;
    check_outputs();
  endtask

  task automatic park();
    mif.rdy_in = 1'b1;
    mif.mem_wr = 1'b0;
    mif.mem_addr = 32'h0000_0100;
    mif.mem_w_data = 8'h00;
    mif.io_out_ready = 1'b0;
    mif.io_in_valid = 1'b0;
    mif.io_in_data = 8'h00;
  endtask

  task automatic bus_access(bit wr, logic [31:0] addr, logic [7:0] d);
    mif.mem_wr = wr;
    mif.mem_addr = addr;
    mif.mem_w_data = d;
    step();
    mif.mem_wr = 1'b0;
    mif.mem_addr = 32'h0000_0100;
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic do_reset();
    #3 rst_n_in = 1'b0;
    #1;
    m_in.delete();
    m_out.delete();
    m_r = 8'h00;
    m_r_known = 1;
    m_ovf = 0;
    m_halt = 0;
    check_outputs();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  initial begin
    park();
    m_r = 8'h00;
    m_r_known = 1;
    #1;
    check_outputs();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // RAM write then read, and address wrap.
    bus_access(1, 32'h0000_0010, 8'hA5);
    bus_access(0, 32'h0000_0010, 8'h00);
    chk("ram_a5", mif.mem_r_data, 8'hA5);
    bus_access(1, 32'h0002_0000, 8'h3C);
    bus_access(0, 32'h0000_0000, 8'h00);
    chk("ram_wrap", mif.mem_r_data, 8'h3C);

    // Overfill the output FIFO, then drain.
    for (int i = 0; i < 17; i++) bus_access(1, 32'h0003_0000, 8'(8'h10 + i));
    step();
    chk("ovf_valid", mif.io_out_valid, 1);
    chk("ovf_flag", mif.io_overflow, 1);
    mif.io_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", mif.io_out_data, 8'(8'h10 + i));
      step();
    end
    chk("drained", mif.io_out_valid, 0);
    mif.io_out_ready = 1'b0;

    // Host byte into the input FIFO, popped by bus reads, then status.
    mif.io_in_valid = 1'b1;
    mif.io_in_data = 8'h41;
    step();
    mif.io_in_valid = 1'b0;
    bus_access(0, 32'h0003_0000, 8'h00);
    chk("in_pop", mif.mem_r_data, 8'h41);
    bus_access(0, 32'h0003_0000, 8'h00);
    chk("in_empty_rd", mif.mem_r_data, 8'h00);
    bus_access(0, 32'h0003_0004, 8'h00);
    chk("status", mif.mem_r_data, 8'h02);

    // rdy_in low stalls the push until it rises.
    mif.rdy_in = 1'b0;
    mif.mem_wr = 1'b1;
    mif.mem_addr = 32'h0003_0000;
    mif.mem_w_data = 8'h77;
    for (int i = 0; i < 3; i++) step();
    chk("stall_nopush", mif.io_out_valid, 0);
    mif.rdy_in = 1'b1;
    step();
    park();
    chk("stall_push", mif.io_out_data, 8'h77);

    // Halt, then reset mid-stream.
    bus_access(1, 32'h0003_0004, 8'h5A);
    chk("halt_set", mif.halt, 1);
    mif.io_in_valid = 1'b1;
    mif.io_in_data = 8'h99;
    step();
    do_reset();
    park();
    step();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      int sel = int'($urandom_range(0, 7));
      mif.rdy_in = ($urandom_range(0, 4) != 0);
      mif.mem_wr = $urandom_range(0, 1) != 0;
      mif.mem_w_data = 8'($urandom);
      if (sel < 4) begin
        mif.mem_addr = 32'($urandom_range(0, 31))
                     | ($urandom_range(0, 1) != 0 ? 32'h0002_0000 : 32'h0)
                     | ($urandom_range(0, 1) != 0 ? 32'h1230_0000 : 32'h0);
      end else if (sel < 6) begin
        mif.mem_addr = 32'h0003_0000;
      end else if (sel == 6) begin
        mif.mem_addr = 32'h0003_0004;
        if ($urandom_range(0, 15) != 0) mif.mem_wr = 1'b0;
      end else begin
        mif.mem_addr = 32'h0003_0000 + 32'($urandom_range(0, 7));
      end
      mif.io_out_ready = ($urandom_range(0, 3) == 0);
      mif.io_in_valid = $urandom_range(0, 1) != 0;
      mif.io_in_data = 8'($urandom);
      step();
      if (n == 2000) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
